// File: rtl/color_sequencer.sv
// ---------------------------------------------------------------------------
// color_sequencer
//
// Upstream stage of the light-stick PWM driver. Turns two raw push-buttons
// into the 6-bit rgb_pwm word {R[1:0], G[1:0], B[1:0]} consumed by the PWM
// stage (a channel level of 3 is rendered fully on).
//
//   - Both buttons are synchronized, debounced and edge-detected into
//     one-cycle press pulses.
//   - The mode button walks OFF -> STATIC -> BLINK -> FADE -> OFF.
//   - The colour button steps an 8-entry palette (ignored in OFF).
//   - A step timer drives the blink phase and the fade triangle.
//
// Optional feature (compile-time macro AUTO_CYCLE_EN):
//   When defined, every time the fade triangle returns from level 1 to 0 the
//   palette index advances by one. A coincident manual colour press still
//   yields a single increment.
//
// Reset release is expected to be synchronized to clk upstream; assertion is
// fully asynchronous and clears every flop immediately.
//
// Ports:
//   clk        in   system clock (PWM stage domain)
//   rst_n      in   asynchronous active-low reset
//   btn_mode   in   raw mode button, active-high, asynchronous to clk
//   btn_color  in   raw colour button, active-high, asynchronous to clk
//   rgb_pwm    out  registered colour levels R[5:4] G[3:2] B[1:0]
//   mode       out  current mode: 0 OFF, 1 STATIC, 2 BLINK, 3 FADE
// ---------------------------------------------------------------------------
module color_sequencer #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned STEP_CYCLES     = 2500000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_mode,
    input  logic       btn_color,
    output logic [5:0] rgb_pwm,
    output logic [1:0] mode
);

    typedef enum logic [1:0] {
        MODE_OFF    = 2'd0,
        MODE_STATIC = 2'd1,
        MODE_BLINK  = 2'd2,
        MODE_FADE   = 2'd3
    } mode_e;

    localparam int unsigned DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned STEP_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_CYCLES - 1);

`ifdef AUTO_CYCLE_EN
    localparam bit AUTO_CYCLE = 1'b1;
`else
    localparam bit AUTO_CYCLE = 1'b0;
`endif

    // Button vectors: bit 0 = mode button, bit 1 = colour button.
    logic [1:0]      sync1_q, sync2_q;
    logic [1:0]      db_q, db_d;
    logic [1:0]      db_prev_q;
    logic [DB_W-1:0] db_cnt_q [2];
    logic [DB_W-1:0] db_cnt_d [2];
    logic [1:0]      press;
    logic            mode_press, color_press;

    mode_e           state_q, state_d;
    logic [STEP_W-1:0] step_cnt_q, step_cnt_d;
    logic            tick;
    logic            phase_q, phase_d;
    logic [1:0]      level_q, level_d;
    logic            dir_up_q, dir_up_d;
    logic            fade_wrap;
    logic [2:0]      color_idx_q, color_idx_d;
    logic            color_inc;
    logic [5:0]      pal;
    logic [5:0]      rgb_q, rgb_d;

    function automatic logic [5:0] palette(input logic [2:0] idx);
        logic [5:0] c;
        case (idx)
            3'd0:    c = 6'b11_00_00;
            3'd1:    c = 6'b11_11_00;
            3'd2:    c = 6'b00_11_00;
            3'd3:    c = 6'b00_11_11;
            3'd4:    c = 6'b00_00_11;
            3'd5:    c = 6'b11_00_11;
            3'd6:    c = 6'b11_11_11;
            default: c = 6'b01_01_01;
        endcase
        return c;
    endfunction

    function automatic logic [1:0] min2(input logic [1:0] a, input logic [1:0] b);
        return (a < b) ? a : b;
    endfunction

    // ---------------------------------------------------------------------
    // Debounce: the counter only runs while the synced level disagrees with
    // the accepted state; any agreement restarts the qualification window.
    // ---------------------------------------------------------------------
    always_comb begin
        // NOTE: every combinational output gets a default before any branch,
        // so no path leaves a signal unassigned and no latch is inferred.
        db_d = db_q;
        for (int b = 0; b < 2; b++) begin
            db_cnt_d[b] = '0;
            if (sync2_q[b] != db_q[b]) begin
                if (db_cnt_q[b] == DB_LAST) begin
                    db_d[b] = sync2_q[b];
                end else begin
                    db_cnt_d[b] = db_cnt_q[b] + 1'b1;
                end
            end
        end
    end

    // Rising edge of the debounced level only; releases never pulse.
    assign press       = db_q & ~db_prev_q;
    assign mode_press  = press[0];
    assign color_press = press[1];

    // ---------------------------------------------------------------------
    // Mode FSM
    // ---------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (mode_press) begin
            case (state_q)
                MODE_OFF:    state_d = MODE_STATIC;
                MODE_STATIC: state_d = MODE_BLINK;
                MODE_BLINK:  state_d = MODE_FADE;
                default:     state_d = MODE_OFF;
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // Step timer and animation state. A mode change restarts the timer so
    // every animation begins with a full step period.
    // ---------------------------------------------------------------------
    assign tick = (step_cnt_q == STEP_LAST);

    always_comb begin
        step_cnt_d = step_cnt_q + 1'b1;
        if (mode_press || tick) begin
            step_cnt_d = '0;
        end
    end

    always_comb begin
        phase_d   = phase_q;
        level_d   = level_q;
        dir_up_d  = dir_up_q;
        fade_wrap = 1'b0;

        if (state_d == MODE_BLINK && state_q != MODE_BLINK) begin
            phase_d = 1'b1;
        end else if (tick && state_q == MODE_BLINK) begin
            phase_d = ~phase_q;
        end

        if (state_d == MODE_FADE && state_q != MODE_FADE) begin
            level_d  = 2'd0;
            dir_up_d = 1'b1;
        end else if (tick && state_q == MODE_FADE && !mode_press) begin
            // Triangle 0,1,2,3,2,1,0,...: direction flips on arriving at an
            // endpoint so neither endpoint is held for two steps.
            if (dir_up_q) begin
                level_d = level_q + 2'd1;
                if (level_q == 2'd2) dir_up_d = 1'b0;
            end else begin
                level_d = level_q - 2'd1;
                if (level_q == 2'd1) begin
                    dir_up_d  = 1'b1;
                    fade_wrap = 1'b1;
                end
            end
        end
    end

    // ---------------------------------------------------------------------
    // Colour index: the OFF gate uses the pre-update mode, so a press that
    // coincides with leaving OFF is still ignored. OR-ing the two sources
    // keeps a coincident manual + automatic advance to a single step.
    // ---------------------------------------------------------------------
    always_comb begin
        color_inc   = (color_press && state_q != MODE_OFF) || (AUTO_CYCLE && fade_wrap);
        color_idx_d = color_inc ? color_idx_q + 3'd1 : color_idx_q;
    end

    // ---------------------------------------------------------------------
    // Output colour, registered one cycle behind the state registers.
    // ---------------------------------------------------------------------
    assign pal = palette(color_idx_q);

    always_comb begin
        rgb_d = '0;
        case (state_q)
            MODE_STATIC: rgb_d = pal;
            MODE_BLINK:  rgb_d = phase_q ? pal : 6'd0;
            MODE_FADE:   rgb_d = {min2(pal[5:4], level_q),
                                  min2(pal[3:2], level_q),
                                  min2(pal[1:0], level_q)};
            default:     rgb_d = '0;
        endcase
    end

    // ---------------------------------------------------------------------
    // State registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            db_q        <= '0;
            db_prev_q   <= '0;
            for (int b = 0; b < 2; b++) db_cnt_q[b] <= '0;
            state_q     <= MODE_OFF;
            step_cnt_q  <= '0;
            phase_q     <= 1'b0;
            level_q     <= 2'd0;
            dir_up_q    <= 1'b1;
            color_idx_q <= 3'd0;
            rgb_q       <= '0;
        end else begin
            // NOTE: non-blocking assignments make every flop sample the
            // pre-edge values, which the synchronizer chain relies on.
            sync1_q     <= {btn_color, btn_mode};
            sync2_q     <= sync1_q;
            db_q        <= db_d;
            db_prev_q   <= db_q;
            for (int b = 0; b < 2; b++) db_cnt_q[b] <= db_cnt_d[b];
            state_q     <= state_d;
            step_cnt_q  <= step_cnt_d;
            phase_q     <= phase_d;
            level_q     <= level_d;
            dir_up_q    <= dir_up_d;
            color_idx_q <= color_idx_d;
            rgb_q       <= rgb_d;
        end
    end

    assign rgb_pwm = rgb_q;
    assign mode    = state_q;

endmodule
